// File: rtl/seq_chk_pkg.sv
// rtl/seq_chk_pkg.sv - shared constants and helpers for the sequence implication checker
package seq_chk_pkg;

  // Sequence length: one `a` position, NUM_B `b` positions, NUM_C `c` positions.
  function automatic int seq_len(input int num_b, input int num_c);
    return 1 + num_b + num_c;
  endfunction

  function automatic logic [31:0] cnt_max(input int width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_chk_lane.sv
// rtl/seq_chk_lane.sv - one group's attempt tracker, pass/fail pulses and saturating fail counter
module seq_chk_lane
  import seq_chk_pkg::*;
#(
  parameter int NUM_B = 2,
  parameter int NUM_C = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             match,
  output logic             fail,
  output logic             fail_next,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int          P    = seq_len(NUM_B, NUM_C);
  localparam int          SW   = P - 1;
  localparam logic [31:0] MAXV = cnt_max(CNT_W);

  logic [SW-1:0]    st_q, st_d;
  logic             match_q, match_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             seq_end;

  // Bit k means some attempt has matched positions 0..k; attempts at the same position merge.
  always_comb begin
    st_d = '0;
    if (en) begin
      st_d[0] = a;
      for (int k = 1; k < SW; k++) begin
        st_d[k] = st_q[k-1] & ((k <= NUM_B) ? b : c);
      end
    end
  end

  assign seq_end = st_q[SW-1] & c;

  always_comb begin
    match_d  = en & seq_end & d;
    fail_d   = en & seq_end & ~d;
    cnt_base = clr ? '0 : cnt_q;
    cnt_d    = fail_d ? CNT_W'(sat_inc(32'(cnt_base), MAXV)) : cnt_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= '0;
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      match_q <= match_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign fail      = fail_q;
  assign fail_next = fail_d;
  assign fail_cnt  = cnt_q;

endmodule

// File: rtl/seq_impl_checker.sv
// rtl/seq_impl_checker.sv - checks a ##1 b[*NUM_B] ##1 c[*NUM_C] |-> d on NUM_CH groups
module seq_impl_checker #(
  parameter int  NUM_CH = 2,
  parameter int  NUM_B  = 2,
  parameter int  NUM_C  = 3,
  parameter int  CNT_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  input  logic [NUM_CH-1:0]       c,
  input  logic [NUM_CH-1:0]       d,
  output logic [NUM_CH-1:0]       match,
  output logic [NUM_CH-1:0]       fail,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic                    err_sticky,
  output logic                    first_fail_vld,
  output logic [CH_W-1:0]         first_fail_ch
);

  logic [NUM_CH-1:0] fail_next;
  logic              sticky_q, sticky_d;
  logic              ff_vld_q, ff_vld_d;
  logic [CH_W-1:0]   ff_ch_q, ff_ch_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    seq_chk_lane #(
      .NUM_B(NUM_B),
      .NUM_C(NUM_C),
      .CNT_W(CNT_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (clr),
      .a        (a[i]),
      .b        (b[i]),
      .c        (c[i]),
      .d        (d[i]),
      .match    (match[i]),
      .fail     (fail[i]),
      .fail_next(fail_next[i]),
      .fail_cnt (fail_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Clear applies before the new failure so a coincident fail is captured fresh.
  always_comb begin
    sticky_d = (clr ? 1'b0 : sticky_q) | (|fail_next);
    ff_vld_d = clr ? 1'b0 : ff_vld_q;
    ff_ch_d  = clr ? '0 : ff_ch_q;
    if (!ff_vld_d && (|fail_next)) begin
      ff_vld_d = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (fail_next[i]) ff_ch_d = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      ff_vld_q <= 1'b0;
      ff_ch_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      ff_vld_q <= ff_vld_d;
      ff_ch_q  <= ff_ch_d;
    end
  end

  assign err_sticky     = sticky_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_ch  = ff_ch_q;

endmodule

// File: tb/tb_seq_impl_checker.sv
// tb/tb_seq_impl_checker.sv - randomized and directed bench with a window-based reference model
module tb_seq_impl_checker;

  localparam int NUM_CH = 2;
  localparam int NUM_B  = 2;
  localparam int NUM_C  = 3;
  localparam int P      = 1 + NUM_B + NUM_C;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [1:0]  a, b, c, d;
  logic [1:0]  match, fail, match_s, fail_s;
  logic [15:0] fail_cnt;
  logic [3:0]  fail_cnt_s;
  logic        err_sticky, first_fail_vld, err_sticky_s, first_fail_vld_s;
  logic [0:0]  first_fail_ch, first_fail_ch_s;

  seq_impl_checker #(.NUM_CH(NUM_CH), .NUM_B(NUM_B), .NUM_C(NUM_C), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .match(match), .fail(fail), .fail_cnt(fail_cnt), .err_sticky(err_sticky),
    .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch));

  seq_impl_checker #(.NUM_CH(NUM_CH), .NUM_B(NUM_B), .NUM_C(NUM_C), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .match(match_s), .fail(fail_s), .fail_cnt(fail_cnt_s), .err_sticky(err_sticky_s),
    .first_fail_vld(first_fail_vld_s), .first_fail_ch(first_fail_ch_s));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] a, b, c, d;
    logic       en;
  } samp_t;

  samp_t      hist[$];
  logic [1:0] e_match, e_fail;
  int         e_cnt[2], e_cnt_s[2], e_ch;
  bit         e_sticky, e_vld;
  logic [1:0] obs_m[$], obs_f[$], exp_m[$], exp_f[$];
  int         checks = 0, errors = 0;

  // Reference: the property holds over a window of the last P samples, all with en high.
  task automatic model_edge();
    samp_t s;
    bit    ok;
    e_match = '0;
    e_fail  = '0;
    if (rst) begin
      hist.delete();
      e_cnt = '{0, 0}; e_cnt_s = '{0, 0};
      e_sticky = 0; e_vld = 0; e_ch = 0;
      return;
    end
    s.a = a; s.b = b; s.c = c; s.d = d; s.en = en;
    hist.push_back(s);
    if (hist.size() > P) void'(hist.pop_front());
    if (clr) begin
      e_cnt = '{0, 0}; e_cnt_s = '{0, 0};
      e_sticky = 0; e_vld = 0; e_ch = 0;
    end
    for (int g = 0; g < NUM_CH; g++) begin
      if (hist.size() == P) begin
        ok = 1;
        for (int k = 0; k < P; k++) begin
          if (!hist[k].en) ok = 0;
          if (k == 0) begin
            if (!hist[k].a[g]) ok = 0;
          end else if (k <= NUM_B) begin
            if (!hist[k].b[g]) ok = 0;
          end else if (!hist[k].c[g]) ok = 0;
        end
        if (ok) begin
          if (hist[P-1].d[g]) e_match[g] = 1'b1;
          else e_fail[g] = 1'b1;
        end
      end
    end
    for (int g = 0; g < NUM_CH; g++) begin
      if (e_fail[g]) begin
        e_cnt[g]   = (e_cnt[g] < 255) ? e_cnt[g] + 1 : 255;
        e_cnt_s[g] = (e_cnt_s[g] < 3) ? e_cnt_s[g] + 1 : 3;
        e_sticky   = 1;
        if (!e_vld) begin
          e_vld = 1;
          e_ch  = g;
        end
      end
    end
  endtask

  task automatic step(input logic [1:0] ia, ib, ic, id, input logic ien, iclr, irst);
    a = ia; b = ib; c = ic; d = id; en = ien; clr = iclr; rst = irst;
    @(posedge clk);
    model_edge();
    #1;
    obs_m.push_back(match); obs_f.push_back(fail);
    exp_m.push_back(e_match); exp_f.push_back(e_fail);
  endtask

  task automatic clear_log();
    obs_m.delete(); obs_f.delete(); exp_m.delete(); exp_f.delete();
  endtask

  // Canonical run: a@0, b@1-2, c@3-5, d@5 on the groups in mask, then idle.
  task automatic run_seq(input logic [1:0] mask, input bit dv, input bit brk,
                         input int rst_at, input int en_off_at);
    clear_log();
    for (int t = 0; t < 8; t++) begin
      step((t == 0) ? mask : 2'b00,
           ((t >= 1 && t <= 2) && !(brk && t == 2)) ? mask : 2'b00,
           (t >= 3 && t <= 5) ? mask : 2'b00,
           (t == 5 && dv) ? mask : 2'b00,
           t != en_off_at, 1'b0, t == rst_at);
    end
  endtask

  task automatic test_reset();
    step(2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1);
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({match, fail, fail_cnt, err_sticky, first_fail_vld, first_fail_ch} !== '0) begin
      errors++;
      $display("FAIL reset_state got m=%b f=%b cnt=%h st=%b vld=%b ch=%b want all zero",
               match, fail, fail_cnt, err_sticky, first_fail_vld, first_fail_ch);
    end
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_match();
    run_seq(2'b01, 1'b1, 1'b0, -1, -1);
    foreach (obs_m[t]) begin
      checks++;
      if (obs_m[t] !== exp_m[t] || obs_f[t] !== exp_f[t]) begin
        errors++;
        $display("FAIL match_pulses cyc %0d got m=%b f=%b want m=%b f=%b", t, obs_m[t], obs_f[t], exp_m[t], exp_f[t]);
      end
    end
    checks++;
    if (obs_m[5] !== 2'b01 || fail_cnt[7:0] !== 8'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL match_directed got m5=%b cnt=%0d st=%b want 01 0 0", obs_m[5], fail_cnt[7:0], err_sticky);
    end
  endtask

  task automatic test_fail();
    run_seq(2'b01, 1'b0, 1'b0, -1, -1);
    foreach (obs_m[t]) begin
      checks++;
      if (obs_m[t] !== exp_m[t] || obs_f[t] !== exp_f[t]) begin
        errors++;
        $display("FAIL fail_pulses cyc %0d got m=%b f=%b want m=%b f=%b", t, obs_m[t], obs_f[t], exp_m[t], exp_f[t]);
      end
    end
    checks++;
    if (obs_f[5] !== 2'b01 || fail_cnt[7:0] !== 8'd1 || err_sticky !== 1'b1 ||
        first_fail_vld !== 1'b1 || first_fail_ch !== 1'b0) begin
      errors++;
      $display("FAIL fail_directed got f5=%b cnt=%0d st=%b vld=%b ch=%b want 01 1 1 1 0",
               obs_f[5], fail_cnt[7:0], err_sticky, first_fail_vld, first_fail_ch);
    end
  endtask

  task automatic test_overlap();
    int nf;
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    clear_log();
    for (int t = 0; t < 9; t++) begin
      step((t <= 1) ? 2'b01 : 2'b00, (t >= 1 && t <= 3) ? 2'b01 : 2'b00,
           (t >= 3 && t <= 6) ? 2'b01 : 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    end
    nf = 0;
    foreach (obs_f[t]) begin
      nf += int'(obs_f[t][0]);
      checks++;
      if (obs_m[t] !== exp_m[t] || obs_f[t] !== exp_f[t]) begin
        errors++;
        $display("FAIL overlap_pulses cyc %0d got m=%b f=%b want m=%b f=%b", t, obs_m[t], obs_f[t], exp_m[t], exp_f[t]);
      end
    end
    checks++;
    if (nf != 2 || obs_f[5] !== 2'b01 || obs_f[6] !== 2'b01 || fail_cnt[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL overlap_directed got nfail=%0d cnt=%0d want 2 2", nf, fail_cnt[7:0]);
    end
  endtask

  task automatic test_broken_priority();
    run_seq(2'b01, 1'b0, 1'b1, -1, -1);
    foreach (obs_m[t]) begin
      checks++;
      if (obs_m[t] !== 2'b00 || obs_f[t] !== 2'b00 || exp_f[t] !== 2'b00) begin
        errors++;
        $display("FAIL broken_run cyc %0d got m=%b f=%b model f=%b want none", t, obs_m[t], obs_f[t], exp_f[t]);
      end
    end
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    run_seq(2'b11, 1'b0, 1'b0, -1, -1);
    checks++;
    if (obs_f[5] !== 2'b11 || first_fail_vld !== 1'b1 || first_fail_ch !== 1'b0 || e_ch != 0) begin
      errors++;
      $display("FAIL prio_same_cycle got f5=%b vld=%b ch=%b want 11 1 0", obs_f[5], first_fail_vld, first_fail_ch);
    end
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    run_seq(2'b10, 1'b0, 1'b0, -1, -1);
    checks++;
    if (first_fail_vld !== 1'b1 || first_fail_ch !== 1'b1 || fail_cnt[15:8] !== 8'(e_cnt[1])) begin
      errors++;
      $display("FAIL prio_group1 got vld=%b ch=%b cnt1=%0d want 1 1 %0d", first_fail_vld, first_fail_ch,
               fail_cnt[15:8], e_cnt[1]);
    end
  endtask

  task automatic test_saturation();
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    clear_log();
    for (int t = 0; t < 12; t++) step(2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fail_cnt_s[1:0] !== 2'd3 || fail_cnt[7:0] !== 8'(e_cnt[0]) || e_cnt[0] != 7) begin
      errors++;
      $display("FAIL saturate got cnt_s=%0d cnt=%0d want 3 7", fail_cnt_s[1:0], fail_cnt[7:0]);
    end
    step(2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
    checks++;
    if (fail_cnt_s[1:0] !== 2'd1 || fail_cnt[7:0] !== 8'd1 || err_sticky !== 1'b1 ||
        first_fail_vld !== 1'b1 || first_fail_ch !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_fail got cnt_s=%0d cnt=%0d st=%b vld=%b want 1 1 1 1",
               fail_cnt_s[1:0], fail_cnt[7:0], err_sticky, first_fail_vld);
    end
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_kill();
    run_seq(2'b01, 1'b1, 1'b0, 4, -1);
    checks++;
    if (obs_m[5] !== 2'b00 || exp_m[5] !== 2'b00 ||
        {match, fail, fail_cnt, err_sticky, first_fail_vld, first_fail_ch} !== '0) begin
      errors++;
      $display("FAIL rst_mid_run got m5=%b cnt=%h st=%b vld=%b want all zero", obs_m[5], fail_cnt, err_sticky, first_fail_vld);
    end
    run_seq(2'b01, 1'b1, 1'b0, -1, 3);
    foreach (obs_m[t]) begin
      checks++;
      if (obs_m[t] !== 2'b00 || obs_f[t] !== 2'b00) begin
        errors++;
        $display("FAIL en_low_mid_run cyc %0d got m=%b f=%b want none", t, obs_m[t], obs_f[t]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] ra, rb, rc, rd;
    for (int t = 0; t < 400; t++) begin
      for (int g = 0; g < 2; g++) begin
        ra[g] = $urandom_range(0, 3) != 0;
        rb[g] = $urandom_range(0, 5) != 0;
        rc[g] = $urandom_range(0, 5) != 0;
        rd[g] = $urandom_range(0, 1) != 0;
      end
      step(ra, rb, rc, rd, $urandom_range(0, 15) != 0, $urandom_range(0, 40) == 0, 1'b0);
      checks++;
      if (match !== e_match || fail !== e_fail || fail_cnt[7:0] !== 8'(e_cnt[0]) ||
          fail_cnt[15:8] !== 8'(e_cnt[1]) || fail_cnt_s !== {2'(e_cnt_s[1]), 2'(e_cnt_s[0])} ||
          err_sticky !== e_sticky || first_fail_vld !== e_vld ||
          (e_vld && first_fail_ch !== 1'(e_ch))) begin
        errors++;
        $display("FAIL random cyc %0d got m=%b f=%b cnt=%h cnt_s=%h st=%b vld=%b ch=%b want m=%b f=%b cnt=%0d/%0d st=%b vld=%b ch=%0d",
                 t, match, fail, fail_cnt, fail_cnt_s, err_sticky, first_fail_vld, first_fail_ch,
                 e_match, e_fail, e_cnt[1], e_cnt[0], e_sticky, e_vld, e_ch);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    e_cnt = '{0, 0}; e_cnt_s = '{0, 0};
    e_sticky = 0; e_vld = 0; e_ch = 0; e_match = '0; e_fail = '0;
    test_reset();
    test_match();
    test_fail();
    test_overlap();
    test_broken_priority();
    test_saturation();
    test_kill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
